// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: operation kinds, opcodes, funct3/funct7 codes
// and the instruction format selector used by the encoder.
package instr_encoder_pkg;

  localparam logic [3:0] KIND_ADD  = 4'd0;
  localparam logic [3:0] KIND_SUB  = 4'd1;
  localparam logic [3:0] KIND_AND  = 4'd2;
  localparam logic [3:0] KIND_OR   = 4'd3;
  localparam logic [3:0] KIND_SLT  = 4'd4;
  localparam logic [3:0] KIND_ADDI = 4'd5;
  localparam logic [3:0] KIND_LW   = 4'd6;
  localparam logic [3:0] KIND_SW   = 4'd7;
  localparam logic [3:0] KIND_BEQ  = 4'd8;
  localparam logic [3:0] KIND_BLT  = 4'd9;
  localparam logic [3:0] KIND_JAL  = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J} fmt_e;

endpackage

// File: rtl/instr_fmt.sv
// Combinational RV32I packer: (kind, fields) -> instruction word, legality and
// immediate range flag. RANGE_CHECK=0 forces in_range high (silent truncation).
module instr_fmt
  import instr_encoder_pkg::*;
#(
  parameter bit RANGE_CHECK = 1'b0
) (
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal,
  output logic        o_in_range
);

  fmt_e       w_fmt;
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_fits;

  always_comb begin
    w_fmt   = FMT_R;
    w_opc   = OPC_OP;
    w_f3    = F3_ADD;
    w_f7    = F7_ZERO;
    o_legal = 1'b1;
    case (i_kind)
      KIND_ADD:  w_f3 = F3_ADD;
      KIND_SUB:  begin w_f3 = F3_ADD; w_f7 = F7_ALT; end
      KIND_AND:  w_f3 = F3_AND;
      KIND_OR:   w_f3 = F3_OR;
      KIND_SLT:  w_f3 = F3_SLT;
      KIND_ADDI: begin w_fmt = FMT_I; w_opc = OPC_OP_IMM; w_f3 = F3_ADD; end
      KIND_LW:   begin w_fmt = FMT_I; w_opc = OPC_LOAD;   w_f3 = F3_W;   end
      KIND_SW:   begin w_fmt = FMT_S; w_opc = OPC_STORE;  w_f3 = F3_W;   end
      KIND_BEQ:  begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_f3 = F3_BEQ; end
      KIND_BLT:  begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_f3 = F3_BLT; end
      KIND_JAL:  begin w_fmt = FMT_J; w_opc = OPC_JAL; end
      default:   o_legal = 1'b0;
    endcase
  end

  always_comb begin
    o_word = '0;
    w_fits = 1'b1;
    case (w_fmt)
      FMT_R: o_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, w_opc};
      FMT_I: begin
        o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, w_opc};
        w_fits = (&i_imm[31:11]) || !(|i_imm[31:11]);
      end
      FMT_S: begin
        o_word = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], w_opc};
        w_fits = (&i_imm[31:11]) || !(|i_imm[31:11]);
      end
      FMT_B: begin
        o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3, i_imm[4:1], i_imm[11], w_opc};
        w_fits = ((&i_imm[31:12]) || !(|i_imm[31:12])) && !i_imm[0];
      end
      FMT_J: begin
        o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_opc};
        w_fits = ((&i_imm[31:20]) || !(|i_imm[31:20])) && !i_imm[0];
      end
      default: o_word = '0;
    endcase
  end

  assign o_in_range = !RANGE_CHECK || w_fits;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder with one-stage registered output, address counter and
// emitted-word counter. Define ENC_RANGE_CHECK_EN to drop out-of-range immediates.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        CNT_W     = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  instr_count,
  output logic              err
);

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_in_range;
  logic              w_accept;
  logic              w_drop;
  logic              w_emit;
  logic              w_out_hs;

  logic              r_out_valid;
  logic [31:0]       r_out_word;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  instr_fmt #(.RANGE_CHECK(RANGE_CHECK)) u_fmt (
    .i_kind     (in_kind),
    .i_rd       (in_rd),
    .i_rs1      (in_rs1),
    .i_rs2      (in_rs2),
    .i_imm      (in_imm),
    .o_word     (w_word),
    .o_legal    (w_legal),
    .o_in_range (w_in_range)
  );

  assign in_ready = !restart && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_drop   = !w_legal || !w_in_range;
  assign w_emit   = w_accept && !w_drop;
  assign w_out_hs = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_addr  <= '0;
      r_addr_cnt  <= BASE_ADDR;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else if (restart) begin
      r_out_valid <= 1'b0;
      r_addr_cnt  <= BASE_ADDR;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_out_hs) r_count <= r_count + CNT_W'(1);
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_word;
        r_out_addr  <= r_addr_cnt;
        r_addr_cnt  <= r_addr_cnt + ADDR_W'(4);
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && w_drop) r_err <= 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_word    = r_out_word;
  assign out_addr    = r_out_addr;
  assign instr_count = r_count;
  assign err         = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, backpressure,
// illegal/out-of-range drops, restart and asynchronous reset.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic [15:0] instr_count;
  logic        err;

  int total = 0;
  int bad   = 0;

  instr_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_kind     (in_kind),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_addr    (out_addr),
    .instr_count (instr_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_kind  = k;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    drive(k, rd, rs1, rs2, imm);
    tick();
    in_valid = 1'b0;
  endtask

  logic [3:0]  tbl_kind [6];
  logic [4:0]  tbl_rd   [6];
  logic [4:0]  tbl_rs1  [6];
  logic [4:0]  tbl_rs2  [6];
  logic [31:0] tbl_imm  [6];
  logic [31:0] tbl_word [6];

  initial begin
    tbl_kind[0] = KIND_JAL; tbl_rd[0] = 5'd1; tbl_rs1[0] = 5'd0; tbl_rs2[0] = 5'd0; tbl_imm[0] = 32'hFFFF_FFFC; tbl_word[0] = 32'hFFDF_F0EF;
    tbl_kind[1] = KIND_BLT; tbl_rd[1] = 5'd0; tbl_rs1[1] = 5'd1; tbl_rs2[1] = 5'd2; tbl_imm[1] = 32'hFFFF_FFF8; tbl_word[1] = 32'hFE20_CCE3;
    tbl_kind[2] = KIND_LW;  tbl_rd[2] = 5'd4; tbl_rs1[2] = 5'd2; tbl_rs2[2] = 5'd0; tbl_imm[2] = 32'd16;         tbl_word[2] = 32'h0101_2203;
    tbl_kind[3] = KIND_AND; tbl_rd[3] = 5'd3; tbl_rs1[3] = 5'd1; tbl_rs2[3] = 5'd2; tbl_imm[3] = 32'd0;          tbl_word[3] = 32'h0020_F1B3;
    tbl_kind[4] = KIND_OR;  tbl_rd[4] = 5'd3; tbl_rs1[4] = 5'd1; tbl_rs2[4] = 5'd2; tbl_imm[4] = 32'd0;          tbl_word[4] = 32'h0020_E1B3;
    tbl_kind[5] = KIND_SLT; tbl_rd[5] = 5'd3; tbl_rs1[5] = 5'd1; tbl_rs2[5] = 5'd2; tbl_imm[5] = 32'd0;          tbl_word[5] = 32'h0020_A1B3;

    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #10 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // single ADD, one-cycle latency
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_word", out_word, 32'h0020_81B3);
    chk("add_addr", out_addr, 32'd0);
    chk("add_count_pre", 32'(instr_count), 32'd0);
    tick();
    chk("add_valid_clr", 32'(out_valid), 32'd0);
    chk("add_count", 32'(instr_count), 32'd1);

    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_count", 32'(instr_count), 32'd0);

    // back-to-back SUB, ADDI
    send(KIND_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("sub_word", out_word, 32'h4020_81B3);
    chk("sub_addr", out_addr, 32'd0);
    send(KIND_ADDI, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    chk("addi_word", out_word, 32'hFFF0_0293);
    chk("addi_addr", out_addr, 32'd4);
    chk("addi_valid", 32'(out_valid), 32'd1);
    tick();
    chk("b2b_count", 32'(instr_count), 32'd2);

    // SW, BEQ, then a streamed table of the remaining kinds
    send(KIND_SW, 5'd0, 5'd1, 5'd2, 32'd4);
    chk("sw_word", out_word, 32'h0020_A223);
    chk("sw_addr", out_addr, 32'd8);
    send(KIND_BEQ, 5'd0, 5'd1, 5'd2, 32'd8);
    chk("beq_word", out_word, 32'h0020_8463);
    chk("beq_addr", out_addr, 32'd12);
    for (int i = 0; i < 6; i++) begin
      send(tbl_kind[i], tbl_rd[i], tbl_rs1[i], tbl_rs2[i], tbl_imm[i]);
      chk($sformatf("tbl%0d_word", i), out_word, tbl_word[i]);
      chk($sformatf("tbl%0d_addr", i), out_addr, 32'(16 + 4 * i));
    end
    tick();
    chk("stream_count", 32'(instr_count), 32'd10);

    // backpressure: hold 3 cycles, then release with a request waiting
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    out_ready = 1'b0;
    drive(KIND_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_word", i), out_word, 32'h0020_81B3);
      chk($sformatf("bp%0d_addr", i), out_addr, 32'd40);
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    chk("bp_count_hold", 32'(instr_count), 32'd10);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_word", out_word, 32'h4020_81B3);
    chk("bp_next_addr", out_addr, 32'd44);
    chk("bp_count", 32'(instr_count), 32'd11);
    tick();
    chk("bp_count_end", 32'(instr_count), 32'd12);

    // illegal kind is dropped without advancing the address
    send(4'hF, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("ill_valid", 32'(out_valid), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("ill_next_addr", out_addr, 32'd48);
    chk("ill_err_sticky", 32'(err), 32'd1);
    tick();
    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_err", 32'(err), 32'd0);

    // ADDI imm=2048: dropped with range checking, truncated otherwise
    send(KIND_ADDI, 5'd5, 5'd0, 5'd0, 32'd2048);
`ifdef ENC_RANGE_CHECK_EN
    chk("range_valid", 32'(out_valid), 32'd0);
    chk("range_err", 32'(err), 32'd1);
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("range_next_addr", out_addr, 32'd0);
`else
    chk("trunc_word", out_word, 32'h8000_0293);
    chk("trunc_err", 32'(err), 32'd0);
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("trunc_next_addr", out_addr, 32'd4);
`endif
    tick();

    // restart with a pending word and a request waiting
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    out_ready = 1'b0;
    drive(KIND_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    restart = 1'b1;
    #1;
    chk("rs_in_ready", 32'(in_ready), 32'd0);
    tick();
    restart = 1'b0; in_valid = 1'b0;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_count", 32'(instr_count), 32'd0);
    chk("rs_err", 32'(err), 32'd0);
    out_ready = 1'b1;
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("rs_next_addr", out_addr, 32'd0);
    chk("rs_next_word", out_word, 32'h0020_81B3);

    // asynchronous reset drops the pending word immediately
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", out_addr, 32'd0);
    #5 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
